// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH  = 32;
  localparam int CLA_GROUP  = 4;
  localparam int CLA_STAGES = 2;

  // Group-level propagate/generate pair produced by each lookahead group.
  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;

  // Carry out of a group given its propagate/generate and its carry-in.
  function automatic logic grp_carry(input grp_pg_t pg, input logic cin);
    return pg.g | (pg.p & cin);
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit combinational carry-lookahead block: every internal carry is a
// flat sum-of-products of generate/propagate terms and the group carry-in.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output grp_pg_t          pg
);

  logic [GROUP-1:0] p_s;
  logic [GROUP-1:0] g_s;
  logic [GROUP:0]   c_s;
  logic             gg_s;
  logic             term_s;

  assign p_s = a ^ b;
  assign g_s = a & b;

  // Lookahead carries and group generate, expanded term by term.
  always_comb begin
    c_s    = '0;
    gg_s   = 1'b0;
    term_s = 1'b0;
    c_s[0] = cin;
    for (int i = 1; i <= GROUP; i++) begin
      term_s = cin;
      for (int m = 0; m < i; m++) begin
        term_s = term_s & p_s[m];
      end
      c_s[i] = term_s;
      for (int j = 0; j < i; j++) begin
        term_s = g_s[j];
        for (int m = j + 1; m < i; m++) begin
          term_s = term_s & p_s[m];
        end
        c_s[i] = c_s[i] | term_s;
      end
    end
    for (int j = 0; j < GROUP; j++) begin
      term_s = g_s[j];
      for (int m = j + 1; m < GROUP; m++) begin
        term_s = term_s & p_s[m];
      end
      gg_s = gg_s | term_s;
    end
  end

  assign sum  = p_s ^ c_s[GROUP-1:0];
  assign pg.p = &p_s;
  assign pg.g = gg_s;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder with valid/ready handshake on both sides.
// Optional signed-overflow output enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = CLA_WIDTH,
  parameter int GROUP  = CLA_GROUP,
  parameter int STAGES = CLA_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_PIPE_OVF_EN
 ,output logic             ovf
`endif
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / GROUP;

  if ((STAGES < 1) || (STAGES > 4) || ((WIDTH % (GROUP * STAGES)) != 0)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must divide by GROUP*STAGES and STAGES must be 1..4");
  end

  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] carry_r;
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  b_r   [STAGES];
  logic [WIDTH-1:0]  sum_r [STAGES];

  logic [STAGES-1:0] adv_s;
  logic [STAGES:0]   load_s;
  logic [STAGES-1:0] v_in_s;
  logic [STAGES-1:0] c_in_s;
  logic [STAGES-1:0] c_nx_s;
  logic [WIDTH-1:0]  a_in_s   [STAGES];
  logic [WIDTH-1:0]  b_in_s   [STAGES];
  logic [WIDTH-1:0]  sum_in_s [STAGES];
  logic [WIDTH-1:0]  sum_nx_s [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE-1:0] slice_sum_s;
    logic [NGRP:0]    gc_s;
    logic [WIDTH-1:0] spliced_s;
    grp_pg_t          pg_s [NGRP];

    if (k == 0) begin : g_head
      assign a_in_s[k]   = a;
      assign b_in_s[k]   = b;
      assign sum_in_s[k] = '0;
      assign c_in_s[k]   = cin;
      assign v_in_s[k]   = in_valid;
    end else begin : g_body
      assign a_in_s[k]   = a_r[k-1];
      assign b_in_s[k]   = b_r[k-1];
      assign sum_in_s[k] = sum_r[k-1];
      assign c_in_s[k]   = carry_r[k-1];
      assign v_in_s[k]   = valid_r[k-1];
    end

    assign gc_s[0] = c_in_s[k];

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      localparam int LSB = k * SLICE + g * GROUP;
      cla_group #(.GROUP(GROUP)) u_grp (
        .a   (a_in_s[k][LSB +: GROUP]),
        .b   (b_in_s[k][LSB +: GROUP]),
        .cin (gc_s[g]),
        .sum (slice_sum_s[g*GROUP +: GROUP]),
        .pg  (pg_s[g])
      );
      assign gc_s[g+1] = grp_carry(pg_s[g], gc_s[g]);
    end

    // Drop this slice into the running sum; bits of other slices pass through.
    always_comb begin
      spliced_s                      = sum_in_s[k];
      spliced_s[k*SLICE +: SLICE]    = slice_sum_s;
    end

    assign sum_nx_s[k] = spliced_s;
    assign c_nx_s[k]   = gc_s[NGRP];
  end

  // Backpressure walks from the output toward the input: a stage may load
  // when it is empty or its occupant moves on this same cycle.
  always_comb begin
    adv_s          = '0;
    load_s         = '0;
    load_s[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv_s[k]  = valid_r[k] & load_s[k+1];
      load_s[k] = ~valid_r[k] | adv_s[k];
    end
  end

  assign in_ready = load_s[0] & ~rst;

  // Stage registers: take the upstream contents on a hand-over, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      carry_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        sum_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_s[k]) begin
          valid_r[k] <= v_in_s[k];
          if (v_in_s[k]) begin
            a_r[k]     <= a_in_s[k];
            b_r[k]     <= b_in_s[k];
            sum_r[k]   <= sum_nx_s[k];
            carry_r[k] <= c_nx_s[k];
          end
        end
      end
    end
  end

  assign out_valid = valid_r[STAGES-1];
  assign sum       = sum_r[STAGES-1];
  assign cout      = carry_r[STAGES-1];

`ifdef CLA_PIPE_OVF_EN
  logic ovf_r;
  logic ovf_nx_s;

  // Carry into the MSB equals a^b^sum at that bit; overflow is it XOR cout.
  assign ovf_nx_s = a_in_s[STAGES-1][WIDTH-1] ^ b_in_s[STAGES-1][WIDTH-1]
                  ^ sum_nx_s[STAGES-1][WIDTH-1] ^ c_nx_s[STAGES-1];

  // Overflow flag travels with the last stage so it stays aligned with sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (load_s[STAGES-1] && v_in_s[STAGES-1]) begin
      ovf_r <= ovf_nx_s;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (default 32/4/2 configuration).
// Define CLA_PIPE_OVF_EN to also exercise the overflow output.
module tb_cla_pipe_adder;

  localparam int WIDTH  = 32;
  localparam int GROUP  = 4;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_PIPE_OVF_EN
  logic             ovf;
`endif

  int               n_chk  = 0;
  int               n_pass = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_PIPE_OVF_EN
   ,.ovf       (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vc;
  endtask

  // Called one edge after the input transfer; waits (bounded) for the result.
  task automatic expect_out(input string tag, input logic [WIDTH-1:0] es, input logic ec,
                            input bit chk_lat);
    int lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, " out_valid"}, out_valid, 1);
    if (chk_lat) check({tag, " latency"}, lat, STAGES);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded limit 100000", $time);
    $fatal(1);
  end

  initial begin
    int   bv [3];
    int   exp3 [3];
    int   got;
    int   first;
    int   last;
    int   acc;
    int   seen;
    bit   held;
    logic [WIDTH-1:0] held_sum;

    // Reset behaviour
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    #1;
    check("rst in_ready", in_ready, 0);
    tick();
    tick();
    check("rst out_valid", out_valid, 0);
    check("rst sum", sum, 0);
    check("rst cout", cout, 0);
`ifdef CLA_PIPE_OVF_EN
    check("rst ovf", ovf, 0);
`endif
    rst = 1'b0;
    #1;
    check("post-rst in_ready", in_ready, 1);

    // Single transfer and latency: 26+6 = 32
    drive(32'd26, 32'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_out("lat", 32'd32, 1'b0, 1'b1);
    tick();

    // Wrap-around: all-ones + 1
    drive(32'hFFFF_FFFF, 32'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_out("wrap", 32'd0, 1'b1, 1'b1);
    tick();

    // Carry ripples across the slice boundary
    drive(32'd16777215, 32'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_out("xslice", 32'd16777216, 1'b0, 1'b0);
    tick();

    // Back-to-back 26+0, 26+4, 26+5 with out_ready held high
    bv   = '{0, 4, 5};
    exp3 = '{26, 30, 31};
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        drive(32'd26, bv[c], 1'b0);
        #1;
        check("b2b in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
        #1;
      end
      if (out_valid === 1'b1) begin
        if (got < 3) check("b2b sum", sum, exp3[got]);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      tick();
    end
    check("b2b count", got, 3);
    check("b2b consecutive", last - first, 2);

    // Output stall with input pressure
    out_ready = 1'b0; acc = 0; held = 1'b0; held_sum = '0;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      drive(32'd100 + c, 32'd3 * c, 1'b0);
      #1;
      if (in_ready === 1'b1) begin
        exp_q.push_back(32'd100 + 32'd4 * c);
        acc++;
      end
      if (c == 5) check("stall in_ready low", in_ready, 0);
      if (held) begin
        check("stall hold valid", out_valid, 1);
        check("stall hold sum", sum, held_sum);
      end else if (out_valid === 1'b1) begin
        held     = 1'b1;
        held_sum = sum;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stall accepts", acc, STAGES);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        if (got < exp_q.size()) check("drain order", sum, exp_q[got]);
        got++;
      end
      tick();
    end
    check("drain count", got, acc);

    // Reset with two operands in flight
    out_ready = 1'b0;
    drive(32'd500, 32'd1, 1'b0);
    tick();
    drive(32'd600, 32'd2, 1'b1);
    #1;
    check("inflight in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid-rst in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    check("flush out_valid", out_valid, 0);
    check("flush sum", sum, 0);
    check("flush cout", cout, 0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    check("flush ghosts", seen, 0);

    // Pipeline still works after the flush
    drive(32'd1, 32'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_out("post-flush", 32'd3, 1'b0, 1'b1);
    tick();

`ifdef CLA_PIPE_OVF_EN
    drive(32'h7FFF_FFFF, 32'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_out("ovf pos", 32'h8000_0000, 1'b0, 1'b0);
    check("ovf pos flag", ovf, 1);
    tick();

    drive(32'd10, 32'd10, 1'b1);
    tick();
    in_valid = 1'b0;
    expect_out("ovf none", 32'd21, 1'b0, 1'b0);
    check("ovf none flag", ovf, 0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 The block SHALL have parameter GROUP, default 4, bits per carry-lookahead group.
REQ-003 The block SHALL have parameter STAGES, default 2, number of pipeline register stages (legal range 1..4).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid  input  1  operand set a/b/cin is present.
REQ-007 The block SHALL have port in_ready  output  1  block accepts the operand set this cycle.
REQ-008 The block SHALL have ports a and b, each input  WIDTH  unsigned operands.
REQ-009 The block SHALL have port cin  input  1  carry-in.
REQ-010 The block SHALL have port out_valid  output  1  sum/cout hold a completed result.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 The block SHALL have ports sum  output  WIDTH (a+b+cin mod 2^WIDTH) and cout  output  1 (carry out of the MSB).

Function
REQ-013 The block SHALL treat a transfer as occurring on a rising edge where valid and ready are both 1, on either side.
REQ-014 The block SHALL split the carry chain into STAGES equal slices of WIDTH/STAGES bits; slice k SHALL be added in stage k using GROUP-bit lookahead groups, with the slice carry-in taken from the stage k-1 register.
REQ-015 The block SHALL carry unconsumed upper operand bits and already-computed lower sum bits forward unchanged through the stage registers.
REQ-016 The block SHALL produce a result with a latency of exactly STAGES cycles from the input transfer to out_valid when out_ready is held at 1.
REQ-017 The block SHALL sustain one transfer per cycle when out_ready is held at 1.
REQ-018 The block SHALL keep a valid bit per stage; a stage SHALL load when it is empty or when its contents advance in the same cycle.
REQ-019 The block SHALL drive in_ready = !valid[0] || stage 0 advancing; in_ready SHALL depend combinationally only on out_ready and internal state, never on in_valid.
REQ-020 The block SHALL hold sum, cout and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 The block SHALL collapse bubbles: an empty stage SHALL accept from upstream even while the output stalls.
REQ-022 The block SHALL, with all stages full and out_ready=0, drive in_ready=0 and lose or duplicate no result.
REQ-023 The block SHALL, on a cycle with an output transfer and an input transfer together, complete both, with occupancy unchanged.
REQ-024 The block SHALL discard the high bits on wrap-around: all-ones + 1 gives sum 0, cout 1.

Reset
REQ-025 The block SHALL, on rst=1 at a clock edge, clear all stage valid bits, sum and cout; out_valid SHALL be 0 the cycle after.
REQ-026 The block SHALL drive in_ready=0 while rst=1 and SHALL accept input from the first cycle after rst deasserts.
REQ-027 The block SHALL discard in-flight operands on reset mid-operation; they SHALL never appear at the output.

Configuration
REQ-028 The block SHALL, when CLA_PIPE_OVF_EN is defined, add port ovf  output  1  two's-complement signed overflow (carry into MSB XOR cout), aligned with sum and cleared to 0 by reset.
REQ-029 The block SHALL, when CLA_PIPE_OVF_EN is undefined, have no ovf port and no associated logic; all other behaviour SHALL be identical.

Structure
REQ-030 The block SHALL take from shared package cla_pkg the default WIDTH/GROUP/STAGES constants and the group generate/propagate struct typedef.
REQ-031 The block SHALL instantiate sub-module cla_group (GROUP-bit combinational lookahead: a, b, cin -> sum, group P, group G) once per group.
REQ-032 The block SHALL reject at elaboration any configuration where WIDTH is not divisible by GROUP*STAGES or STAGES is outside 1..4.

Verification
REQ-033 The bench SHALL cover: a=26, b=6, cin=0, out_ready=1 -> sum=32, cout=0, out_valid exactly STAGES cycles after the transfer.
REQ-034 The bench SHALL cover: a=FFFFFFFF, b=1, cin=0 -> sum=0, cout=1; a=16777215, b=1 -> sum=16777216, cout=0.
REQ-035 The bench SHALL cover: back-to-back inputs 26+0, 26+4, 26+5 with out_ready=1 -> 26, 30, 31 on consecutive cycles; in_ready held 1.
REQ-036 The bench SHALL cover: out_ready=0 for 6 cycles with in_valid=1 -> in_ready falls after STAGES accepts; on release, results emerge in order, none lost or duplicated.
REQ-037 The bench SHALL cover: rst asserted one cycle with 2 operands in flight -> out_valid=0 next cycle; those results never appear.
REQ-038 The bench SHALL cover, with CLA_PIPE_OVF_EN defined: a=7FFFFFFF, b=1 -> sum=80000000, ovf=1; a=10, b=10, cin=1 -> sum=21, ovf=0.
